dragon_stack: RTL and testbench
===============================

DRAGON_STACK -- requirements
Module: dragon_stack

Interface
REQ-001: Parameter DataWidth, default 36, the width of one stack word.
REQ-002: Parameter Depth, default 512, the number of stack entries; it SHALL be a power of two and at least 4.
REQ-003: Parameter AddressWidth, default 9, SHALL equal log2(Depth).
REQ-004: Clock  input  1  the single clock; all state SHALL change on the rising edge.
REQ-005: ResetN  input  1  reset, asynchronous and active-low.
REQ-006: Push  input  1  push request; sampled on the rising edge.
REQ-007: Pop  input  1  pop request; sampled on the rising edge.
REQ-008: PushData  input  DataWidth  the word written by a push or a replace.
REQ-009: ClearErr  input  1  synchronous clear of the sticky error flags.
REQ-010: Top  output  DataWidth  the registered top-of-stack word.
REQ-011: Next  output  DataWidth  the registered word directly below the top.
REQ-012: Count  output  AddressWidth+1  the current number of entries, 0..Depth.
REQ-013: Empty  output  1  Count==0; Full  output  1  Count==Depth.
REQ-014: Overflow  output  1  sticky flag for a rejected push; Underflow  output  1  sticky flag for a rejected pop.

Function
REQ-015: The block SHALL decode {Push,Pop} as follows: 00 = idle, 10 = push, 01 = pop, 11 = replace.
REQ-016: A push with Count<Depth SHALL, on the same edge: set Top to PushData, set Next to the old Top, and increment Count.
REQ-017: A pop with Count>0 SHALL, on the same edge: set Top to the old Next, set Next to the entry two below the old top (0 if none), and decrement Count.
REQ-018: A replace with Count>0 SHALL set Top to PushData and leave Next and Count unchanged; this SHALL be legal when Full.
REQ-019: Latency SHALL be one cycle: the outputs after edge N reflect the operation sampled at edge N, so back-to-back operations every cycle are legal without stalls.
REQ-020: Pops every cycle SHALL yield correct Top and Next; entries below Next SHALL be held in a synchronous-read RAM and prefetched so that no bubble occurs.
REQ-021: A push when Full SHALL be ignored (no state change except the flag) and SHALL set Overflow.
REQ-022: A pop or replace when Empty SHALL be ignored and SHALL set Underflow.
REQ-023: Top SHALL read 0 when Count==0, and Next SHALL read 0 when Count<2.
REQ-024: Overflow and Underflow SHALL remain set until ClearErr is sampled high or reset is asserted.
REQ-025: If ClearErr is high in the same cycle as a new error, the flag SHALL end set.
REQ-026: Count arithmetic SHALL NOT wrap: Count stays within 0..Depth under any input sequence.
REQ-027: Empty and Full SHALL be derived from the registered Count and SHALL be valid in the same cycle as Count.
REQ-028: RAM contents beyond Count are don't-care and SHALL never be visible on Top or Next.

Reset
REQ-029: While ResetN is low, the block SHALL force Top=0, Next=0, Count=0, Empty=1, Full=0, Overflow=0 and Underflow=0, independent of Clock.
REQ-030: Asserting ResetN mid-operation SHALL abort the operation, leaving the stack empty; RAM contents need not be cleared.
REQ-031: The first operation SHALL be accepted on the first rising edge after ResetN deasserts.

Verification
REQ-032: After reset, push 0x1, 0x2 and 0x3 on consecutive cycles -> Top=0x3, Next=0x2, Count=3.
REQ-033: Then pop on three consecutive cycles -> (Top,Next) = (0x2,0x1), then (0x1,0), then (0,0) with Empty=1.
REQ-034: Fill to Depth, then push 0xAA -> Count=Depth, Top unchanged, Overflow=1; then replace with 0x55 -> Top=0x55, Count=Depth.
REQ-035: Pop while Empty -> Count=0, Underflow=1; ClearErr for one cycle -> Underflow=0; pop while Empty together with ClearErr -> Underflow=1.
REQ-036: Push 10 random words, then pop 10 times back-to-back -> Top matches the words in LIFO order on every cycle.
REQ-037: Push 5 words, then drop ResetN between clock edges -> all outputs reset immediately; after release, push 0x7 -> Top=0x7, Next=0, Count=1.

Source files
------------

// File: rtl/dragon_stack_if.sv
`default_nettype none
// ============================================================================
// dragon_stack_if : push/pop/replace request and top-of-stack view bundle
// Revision: 1.0
// ============================================================================
interface dragon_stack_if #(
   parameter int DataWidth    = 36,
   parameter int AddressWidth = 9
);
   logic                  push;
   logic                  pop;
   logic                  clr_err;
   logic [DataWidth-1:0]  push_data;
   logic [DataWidth-1:0]  top;
   logic [DataWidth-1:0]  next_word;
   logic [AddressWidth:0] count;
   logic                  empty;
   logic                  full;
   logic                  overflow;
   logic                  underflow;

   modport slave (
      input  push, pop, clr_err, push_data,
      output top, next_word, count, empty, full, overflow, underflow
   );

   modport master (
      output push, pop, clr_err, push_data,
      input  top, next_word, count, empty, full, overflow, underflow
   );
endinterface
`default_nettype wire

// File: rtl/dragon_stack.sv
`default_nettype none
// ============================================================================
// dragon_stack : LIFO with registered Top/Next and a RAM-backed body
// Revision: 1.0
// ============================================================================
module dragon_stack #(
   parameter int DataWidth    = 36,
   parameter int Depth        = 512,
   parameter int AddressWidth = 9
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   dragon_stack_if.slave        bus_io
);
   localparam logic [AddressWidth:0] c_one       = (AddressWidth+1)'(1);
   localparam logic [AddressWidth:0] c_two       = (AddressWidth+1)'(2);
   localparam logic [AddressWidth:0] c_three     = (AddressWidth+1)'(3);
   localparam logic [AddressWidth:0] c_count_max = (AddressWidth+1)'(Depth);

   logic [DataWidth-1:0]    top_q, top_d;
   logic [DataWidth-1:0]    next_q, next_d;
   logic [AddressWidth:0]   count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;

   // Stack entry k (0 = bottom) lives at RAM address k once it sinks below Next.
   logic [DataWidth-1:0]    mem_q [Depth];
   logic [DataWidth-1:0]    prefetch_q;

   logic                    w_empty, w_full;
   logic                    w_do_push, w_do_pop, w_do_repl;
   logic                    w_wr_en;
   logic [AddressWidth-1:0] w_wr_addr, w_rd_addr;

   assign w_empty   = (count_q == '0);
   assign w_full    = (count_q == c_count_max);
   assign w_do_push = bus_io.push & ~bus_io.pop & ~w_full;
   assign w_do_pop  = bus_io.pop & ~bus_io.push & ~w_empty;
   assign w_do_repl = bus_io.push & bus_io.pop & ~w_empty;

   always_comb begin
      top_d   = top_q;
      next_d  = next_q;
      count_d = count_q;
      if (w_do_push) begin
         top_d   = bus_io.push_data;
         next_d  = top_q;
         count_d = count_q + c_one;
      end else if (w_do_pop) begin
         top_d   = next_q;
         next_d  = (count_q >= c_three) ? prefetch_q : '0;
         count_d = count_q - c_one;
      end else if (w_do_repl) begin
         top_d   = bus_io.push_data;
      end
      // A fresh error wins over a simultaneous clear.
      ovf_d = (ovf_q & ~bus_io.clr_err) | (bus_io.push & ~bus_io.pop & w_full);
      unf_d = (unf_q & ~bus_io.clr_err) | (bus_io.pop & w_empty);
   end

   // The old Next sinks into the RAM on a push; the RAM always prefetches the
   // entry that will become Next after a pop from the next-state depth.
   assign w_wr_en   = w_do_push && (count_q >= c_two);
   assign w_wr_addr = AddressWidth'(count_q - c_two);
   assign w_rd_addr = (count_d >= c_three) ? AddressWidth'(count_d - c_three) : '0;

   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         mem_q[w_wr_addr] <= next_q;
      end
      if (w_wr_en && (w_wr_addr == w_rd_addr)) begin
         prefetch_q <= next_q;
      end else begin
         prefetch_q <= mem_q[w_rd_addr];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         top_q   <= '0;
         next_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         next_q  <= next_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus_io.top       = top_q;
   assign bus_io.next_word = next_q;
   assign bus_io.count     = count_q;
   assign bus_io.empty     = w_empty;
   assign bus_io.full      = w_full;
   assign bus_io.overflow  = ovf_q;
   assign bus_io.underflow = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_dragon_stack.sv
`default_nettype none
// ============================================================================
// tb_dragon_stack : directed vector table plus LIFO / fill / reset sequences
// Revision: 1.0
// ============================================================================
module tb_dragon_stack;
   localparam int c_dw    = 36;
   localparam int c_depth = 512;
   localparam int c_aw    = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   dragon_stack_if #(.DataWidth(c_dw), .AddressWidth(c_aw)) bus ();

   dragon_stack #(
      .DataWidth   (c_dw),
      .Depth       (c_depth),
      .AddressWidth(c_aw)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   typedef struct {
      logic            push;
      logic            pop;
      logic            clr;
      logic [c_dw-1:0] data;
      logic [c_dw-1:0] top;
      logic [c_dw-1:0] nxt;
      int              cnt;
      logic            ovf;
      logic            unf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [c_dw-1:0] top, input logic [c_dw-1:0] nxt,
                            input int cnt, input logic ovf, input logic unf);
      check({tag, " top"},   64'(bus.top), 64'(top));
      check({tag, " next"},  64'(bus.next_word), 64'(nxt));
      check({tag, " count"}, 64'(bus.count), 64'(cnt));
      check({tag, " empty"}, 64'(bus.empty), 64'(cnt == 0));
      check({tag, " full"},  64'(bus.full), 64'(cnt == c_depth));
      check({tag, " ovf"},   64'(bus.overflow), 64'(ovf));
      check({tag, " unf"},   64'(bus.underflow), 64'(unf));
   endtask

   // Drive one request, let one rising edge sample it, then settle.
   task automatic op(input logic p, input logic q, input logic c, input logic [c_dw-1:0] d);
      bus.push      = p;
      bus.pop       = q;
      bus.clr_err   = c;
      bus.push_data = d;
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic p, input logic q, input logic c, input logic [c_dw-1:0] d,
                               input logic [c_dw-1:0] t, input logic [c_dw-1:0] n, input int cnt,
                               input logic ovf, input logic unf);
      vec_t v;
      v.push = p; v.pop = q; v.clr = c; v.data = d;
      v.top = t; v.nxt = n; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endfunction

   logic [c_dw-1:0] words [10];

   initial begin
      bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.push_data = '0;

      //            push pop clr data    top    next   cnt ovf unf
      add(1, 0, 0, 36'h1,  36'h1,  36'h0,  1, 0, 0);
      add(1, 0, 0, 36'h2,  36'h2,  36'h1,  2, 0, 0);
      add(1, 0, 0, 36'h3,  36'h3,  36'h2,  3, 0, 0);
      add(0, 1, 0, 36'h0,  36'h2,  36'h1,  2, 0, 0);
      add(0, 1, 0, 36'h0,  36'h1,  36'h0,  1, 0, 0);
      add(0, 1, 0, 36'h0,  36'h0,  36'h0,  0, 0, 0);
      add(0, 1, 0, 36'h0,  36'h0,  36'h0,  0, 0, 1);
      add(0, 0, 1, 36'h0,  36'h0,  36'h0,  0, 0, 0);
      add(0, 1, 1, 36'h0,  36'h0,  36'h0,  0, 0, 1);
      add(0, 0, 1, 36'h0,  36'h0,  36'h0,  0, 0, 0);
      add(1, 1, 0, 36'h9,  36'h0,  36'h0,  0, 0, 1);
      add(0, 0, 1, 36'h0,  36'h0,  36'h0,  0, 0, 0);
      add(1, 0, 0, 36'h10, 36'h10, 36'h0,  1, 0, 0);
      add(1, 0, 0, 36'h20, 36'h20, 36'h10, 2, 0, 0);
      add(1, 1, 0, 36'h30, 36'h30, 36'h10, 2, 0, 0);
      add(1, 0, 0, 36'h40, 36'h40, 36'h30, 3, 0, 0);
      add(1, 0, 0, 36'h50, 36'h50, 36'h40, 4, 0, 0);
      add(0, 1, 0, 36'h0,  36'h40, 36'h30, 3, 0, 0);
      add(1, 0, 0, 36'h60, 36'h60, 36'h40, 4, 0, 0);
      add(0, 1, 0, 36'h0,  36'h40, 36'h30, 3, 0, 0);
      add(0, 1, 0, 36'h0,  36'h30, 36'h10, 2, 0, 0);
      add(0, 1, 0, 36'h0,  36'h10, 36'h0,  1, 0, 0);
      add(0, 1, 0, 36'h0,  36'h0,  36'h0,  0, 0, 0);

      // Reset state is forced without any clock edge.
      #2;
      check_all("reset", '0, '0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         op(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].data);
         check_all($sformatf("vec%0d", i), vecs[i].top, vecs[i].nxt, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
      end

      // LIFO of random words, popped back-to-back.
      for (int i = 0; i < 10; i++) begin
         words[i] = {4'($urandom), 32'($urandom)};
         op(1'b1, 1'b0, 1'b0, words[i]);
      end
      check("lifo full top", 64'(bus.top), 64'(words[9]));
      for (int k = 1; k <= 10; k++) begin
         op(1'b0, 1'b1, 1'b0, '0);
         check($sformatf("lifo pop%0d top", k), 64'(bus.top), (k < 10) ? 64'(words[9-k]) : 64'd0);
         check($sformatf("lifo pop%0d next", k), 64'(bus.next_word), (k < 9) ? 64'(words[8-k]) : 64'd0);
      end

      // Fill to Depth, overflow, replace when full, then drain.
      for (int i = 0; i < c_depth; i++) op(1'b1, 1'b0, 1'b0, 36'(i + 1));
      check_all("filled", 36'(c_depth), 36'(c_depth - 1), c_depth, 1'b0, 1'b0);
      op(1'b1, 1'b0, 1'b0, 36'hAA);
      check_all("overflow", 36'(c_depth), 36'(c_depth - 1), c_depth, 1'b1, 1'b0);
      op(1'b1, 1'b1, 1'b0, 36'h55);
      check_all("replace full", 36'h55, 36'(c_depth - 1), c_depth, 1'b1, 1'b0);
      op(1'b0, 0, 1'b1, '0);
      check("ovf cleared", 64'(bus.overflow), 64'd0);
      for (int k = 1; k <= c_depth; k++) begin
         int c;
         c = c_depth - k;
         op(1'b0, 1'b1, 1'b0, '0);
         check($sformatf("drain%0d top", k), 64'(bus.top), 64'(c));
         check($sformatf("drain%0d next", k), 64'(bus.next_word), (c >= 2) ? 64'(c - 1) : 64'd0);
         check($sformatf("drain%0d count", k), 64'(bus.count), 64'(c));
      end
      check_all("drained", '0, '0, 0, 1'b0, 1'b0);

      // Asynchronous reset between clock edges.
      for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b0, 36'(i + 100));
      check_all("pre-reset", 36'd104, 36'd103, 5, 1'b0, 1'b0);
      op(1'b0, 1'b0, 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async reset", '0, '0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      op(1'b1, 1'b0, 1'b0, 36'h7);
      check_all("post-reset push", 36'h7, '0, 1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
